sync_w2r_ptr: RTL and testbench



---
 rtl/sync_w2r_ptr.sv | 67 ++++++
 tb/tb_sync_w2r_ptr.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sync_w2r_ptr.sv
// Multi-flop synchronizer for the Gray-coded async FIFO write pointer into the read domain.
// Optional SYNC_W2R_PTR_BIN_EN adds a registered binary copy of the synchronized pointer.
module sync_w2r_ptr #(
  parameter int PTR_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 r_clk_i,
  input  logic                 r_rst_i,
  input  logic [PTR_WIDTH-1:0] w_ptr_i,
`ifdef SYNC_W2R_PTR_BIN_EN
  output logic [PTR_WIDTH-1:0] r_w_ptr_bin_o,
`endif
  output logic [PTR_WIDTH-1:0] r_w_ptr_o
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("sync_w2r_ptr: SYNC_STAGES must be >= 2");
    end
    if (PTR_WIDTH < 2) begin : g_bad_width
      $error("sync_w2r_ptr: PTR_WIDTH must be >= 2");
    end
  endgenerate

  // Plain flop chain: no enables or muxes, so only one Gray bit can be in flight.
  (* ASYNC_REG = "TRUE", dont_retime = "true" *)
  logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge r_clk_i) begin
    if (r_rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= w_ptr_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign r_w_ptr_o = sync_q[SYNC_STAGES-1];

`ifdef SYNC_W2R_PTR_BIN_EN
  logic [PTR_WIDTH-1:0] bin_d;
  logic [PTR_WIDTH-1:0] bin_q;

  always_comb begin
    bin_d = '0;
    bin_d[PTR_WIDTH-1] = r_w_ptr_o[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      bin_d[i] = bin_d[i+1] ^ r_w_ptr_o[i];
    end
  end

  always_ff @(posedge r_clk_i) begin
    if (r_rst_i) begin
      bin_q <= '0;
    end else begin
      bin_q <= bin_d;
    end
  end

  assign r_w_ptr_bin_o = bin_q;
`endif

endmodule

// File: tb/tb_sync_w2r_ptr.sv
// Scoreboard bench for sync_w2r_ptr: directed vectors push expected outputs, a monitor checks them.
// Define SYNC_W2R_PTR_BIN_EN to also check the binary output.
module tb_sync_w2r_ptr;

  logic       r_clk_i = 1'b0;
  logic       r_rst_i = 1'b1;
  logic [7:0] w_ptr_i = 8'h00;
  logic [7:0] r_w_ptr_o;
`ifdef SYNC_W2R_PTR_BIN_EN
  logic [7:0] r_w_ptr_bin_o;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
`ifdef SYNC_W2R_PTR_BIN_EN
  logic [7:0] exp_bin_q[$];
  logic [7:0] prev_exp = 8'h00;
`endif

  always #5 r_clk_i = ~r_clk_i;

  sync_w2r_ptr #(.PTR_WIDTH(8), .SYNC_STAGES(2)) dut (
    .r_clk_i   (r_clk_i),
    .r_rst_i   (r_rst_i),
    .w_ptr_i   (w_ptr_i),
`ifdef SYNC_W2R_PTR_BIN_EN
    .r_w_ptr_bin_o(r_w_ptr_bin_o),
`endif
    .r_w_ptr_o (r_w_ptr_o)
  );

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Drive inputs for the next edge and queue the output expected right after it.
  task automatic apply(input logic rst, input logic [7:0] w, input logic [7:0] exp);
    @(negedge r_clk_i);
    r_rst_i = rst;
    w_ptr_i = w;
    exp_q.push_back(exp);
`ifdef SYNC_W2R_PTR_BIN_EN
    exp_bin_q.push_back(rst ? 8'h00 : g2b(prev_exp));
    prev_exp = exp;
`endif
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(posedge r_clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (r_w_ptr_o !== e) begin
          errors++;
          $display("FAIL r_w_ptr_o @%0t: got %02h want %02h", $time, r_w_ptr_o, e);
        end
      end
`ifdef SYNC_W2R_PTR_BIN_EN
      if (exp_bin_q.size() > 0) begin
        e = exp_bin_q.pop_front();
        checks++;
        if (r_w_ptr_bin_o !== e) begin
          errors++;
          $display("FAIL r_w_ptr_bin_o @%0t: got %02h want %02h", $time, r_w_ptr_bin_o, e);
        end
      end
`endif
    end
  end

  initial begin : driver
    // reset hold
    repeat (3) apply(1'b1, 8'h08, 8'h00);
    // release: two-edge latency then hold
    apply(1'b0, 8'h08, 8'h00);
    apply(1'b0, 8'h08, 8'h08);
    apply(1'b0, 8'h08, 8'h08);
    apply(1'b0, 8'h08, 8'h08);
    // Gray sequence 00,01,03,02 each held two periods
    apply(1'b0, 8'h00, 8'h08);
    apply(1'b0, 8'h00, 8'h00);
    apply(1'b0, 8'h01, 8'h00);
    apply(1'b0, 8'h01, 8'h01);
    apply(1'b0, 8'h03, 8'h01);
    apply(1'b0, 8'h03, 8'h03);
    apply(1'b0, 8'h02, 8'h03);
    apply(1'b0, 8'h02, 8'h02);
    // wrap-around 80 -> 00
    apply(1'b0, 8'h80, 8'h02);
    apply(1'b0, 8'h80, 8'h80);
    apply(1'b0, 8'h80, 8'h80);
    apply(1'b0, 8'h00, 8'h80);
    apply(1'b0, 8'h00, 8'h00);
    // back to 08, then one-edge reset mid-operation
    apply(1'b0, 8'h08, 8'h00);
    apply(1'b0, 8'h08, 8'h08);
    apply(1'b0, 8'h08, 8'h08);
    apply(1'b1, 8'h08, 8'h00);
    apply(1'b0, 8'h08, 8'h00);
    apply(1'b0, 8'h08, 8'h08);
    apply(1'b0, 8'h08, 8'h08);
    // Gray 0C (binary 08), then 80 (binary FF)
    apply(1'b0, 8'h0C, 8'h08);
    apply(1'b0, 8'h0C, 8'h0C);
    apply(1'b0, 8'h0C, 8'h0C);
    apply(1'b0, 8'h80, 8'h0C);
    apply(1'b0, 8'h80, 8'h80);
    apply(1'b0, 8'h80, 8'h80);
    apply(1'b0, 8'h80, 8'h80);
    repeat (2) @(negedge r_clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
